burst_mode_framer: RTL and testbench
====================================

BURST_MODE_FRAMER -- requirements
Module: burst_mode_framer

Interface
REQ-001 Parameter LASER_ON_CYCLES, default 4, number of laser-settle cycles (zero data) before the preamble; legal range 1..255.
REQ-002 Parameter LASER_OFF_CYCLES, default 4, number of zero-data cycles after the last burst word with out_burst_en still high; legal range 1..255.
REQ-003 Parameter PREAMBLE_PATTERN, default 32'hAAAAAAAA, preamble word and underrun fill word.
REQ-004 in_clock  input  1  clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset: synchronous, active-low.
REQ-006 in_start  input  1  burst request, sampled only while out_busy=0.
REQ-007 in_preamble_len  input  8  preamble words, 0..255.
REQ-008 in_syncword  input  32  burst delimiter, captured at start.
REQ-009 in_payload_len  input  12  payload words, 0..4095.
REQ-010 in_payload_data  input  32  payload word.
REQ-011 in_payload_valid  input  1  payload word available.
REQ-012 out_payload_ready  output  1  framer accepts a payload word this cycle.
REQ-013 out_data  output  32  line word; bit 31 is transmitted first.
REQ-014 out_burst_en  output  1  laser/driver enable.
REQ-015 out_busy  output  1  high from start acceptance until return to IDLE.
REQ-016 out_done  output  1  one-cycle pulse on normal burst completion.
REQ-017 out_underrun  output  1  sticky payload-underrun flag.

Function
REQ-018 The FSM SHALL use these states: IDLE, LASER_ON, PREAMBLE, SYNC, PAYLOAD, EOB (only with the macro), LASER_OFF.
REQ-019 In IDLE, in_start=1 at edge N SHALL capture lengths and syncword, enter LASER_ON, and set out_busy=1 and out_burst_en=1 from edge N.
REQ-020 out_data, out_burst_en, out_busy and out_done SHALL be registered; out_payload_ready SHALL be combinational (state==PAYLOAD and words remaining>0).
REQ-021 LASER_ON SHALL drive out_data=0 for exactly LASER_ON_CYCLES cycles.
REQ-022 PREAMBLE SHALL drive PREAMBLE_PATTERN for exactly the captured preamble length; a length of 0 skips the state.
REQ-023 SYNC SHALL drive the captured syncword for exactly one cycle; therefore the syncword appears at edge N+LASER_ON_CYCLES+preamble_len.
REQ-024 In PAYLOAD, valid&ready at edge M SHALL place in_payload_data on out_data from edge M and decrement the remaining count.
REQ-025 In PAYLOAD, valid=0 SHALL drive PREAMBLE_PATTERN without decrementing the count and SHALL set out_underrun.
REQ-026 A payload length of 0 SHALL skip PAYLOAD, and out_payload_ready SHALL never assert for that burst.
REQ-027 LASER_OFF SHALL drive out_data=0 with out_burst_en=1 for LASER_OFF_CYCLES cycles, then return to IDLE with out_burst_en=0, out_busy=0 and out_done=1 for one cycle.
REQ-028 in_start while out_busy=1 SHALL be ignored and not queued; in_start in the same cycle as out_done SHALL be ignored.
REQ-029 out_underrun SHALL clear only on reset or on the next accepted in_start.
REQ-030 In IDLE, out_data SHALL be 0 and out_burst_en SHALL be 0.
REQ-031 Counters SHALL be wide enough for the maximum lengths, with no wrap; the payload counter is 12 bits.

Reset
REQ-032 rst=0 at an edge SHALL force IDLE and out_data=0, out_burst_en=0, out_busy=0, out_done=0, out_underrun=0, with captured registers cleared.
REQ-033 Reset mid-burst SHALL abort the burst immediately, with no out_done and no LASER_OFF tail.
REQ-034 rst has priority over in_start.

Configuration
REQ-035 With macro BURST_MODE_FRAMER_EOB_EN defined, the SHALL-state EOB SHALL follow PAYLOAD (or SYNC if the payload length is 0) and drive ~syncword for one cycle before LASER_OFF.
REQ-036 Without BURST_MODE_FRAMER_EOB_EN, PAYLOAD (or SYNC) SHALL go directly to LASER_OFF, and no EOB logic SHALL exist.

Verification
REQ-037 Defaults, preamble_len=2, syncword=32'hB2C50FA1, payload_len=3, valid always high with data 1,2,3 -> out_data sequence 0,0,0,0,AAAAAAAA,AAAAAAAA,B2C50FA1,1,2,3,(EOB 4D3AF05E if enabled),0,0,0,0; out_done one cycle later; out_burst_en high throughout.
REQ-038 preamble_len=0, payload_len=0 -> syncword directly after 4 zero words; out_payload_ready never high.
REQ-039 payload_len=2, valid low for 3 cycles after PAYLOAD entry -> 3 AAAAAAAA fill words, then both data words; out_underrun=1 until the next start.
REQ-040 rst=0 asserted during the preamble -> next cycle out_burst_en=0, out_busy=0, out_data=0, no out_done.
REQ-041 in_start pulsed mid-payload and in the out_done cycle -> ignored; a single burst only.
REQ-042 preamble_len=255, payload_len=4095 -> exact word counts, no counter wrap, syncword at edge N+4+255.

Source files
------------

// File: rtl/burst_mode_framer.sv
// burst_mode_framer: burst framer emitting laser-on settle, preamble, syncword, payload and laser-off tail.
// Define BURST_MODE_FRAMER_EOB_EN to append a ~syncword end-of-burst word after the payload.
module burst_mode_framer #(
    parameter int          LASER_ON_CYCLES  = 4,
    parameter int          LASER_OFF_CYCLES = 4,
    parameter logic [31:0] PREAMBLE_PATTERN = 32'hAAAAAAAA
) (
    input  logic        in_clock,
    input  logic        rst,
    input  logic        in_start,
    input  logic [7:0]  in_preamble_len,
    input  logic [31:0] in_syncword,
    input  logic [11:0] in_payload_len,
    input  logic [31:0] in_payload_data,
    input  logic        in_payload_valid,
    output logic        out_payload_ready,
    output logic [31:0] out_data,
    output logic        out_burst_en,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_underrun
);
    typedef enum logic [2:0] {
        IDLE, LASER_ON, PREAMBLE, SYNC, PAYLOAD,
`ifdef BURST_MODE_FRAMER_EOB_EN
        EOB,
`endif
        LASER_OFF
    } state_t;

    localparam logic [7:0] LON  = 8'(LASER_ON_CYCLES);
    localparam logic [7:0] LOFF = 8'(LASER_OFF_CYCLES);
`ifdef BURST_MODE_FRAMER_EOB_EN
    localparam state_t TAIL = EOB;
`else
    localparam state_t TAIL = LASER_OFF;
`endif

    // r_state is the segment of the word currently on out_data; r_cnt counts words emitted in it
    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  r_pre_len;
    logic [31:0] r_sync;
    logic [11:0] r_rem;
    logic [31:0] r_data;
    logic        r_burst_en;
    logic        r_busy;
    logic        r_done;
    logic        r_underrun;
    logic        w_start;
    logic        w_hold;
    logic        w_accept;
    logic [31:0] w_data;

    always_ff @(posedge in_clock) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_pre_len  <= 8'd0;
            r_sync     <= 32'd0;
            r_rem      <= 12'd0;
            r_data     <= 32'd0;
            r_burst_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_hold ? r_cnt + 8'd1 : 8'd1;
            if (w_start) begin
                r_pre_len <= in_preamble_len;
                r_sync    <= in_syncword;
                r_rem     <= in_payload_len;
            end else if (w_accept) begin
                r_rem <= r_rem - 12'd1;
            end
            r_data     <= w_data;
            r_burst_en <= w_next != IDLE;
            r_busy     <= w_next != IDLE;
            r_done     <= r_state == LASER_OFF && w_next == IDLE;
            r_underrun <= w_start ? 1'b0 : r_underrun | (out_payload_ready & ~in_payload_valid);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (in_start && !r_done) w_next = LASER_ON;
            LASER_ON:  if (r_cnt == LON) w_next = (r_pre_len != 8'd0) ? PREAMBLE : SYNC;
            PREAMBLE:  if (r_cnt == r_pre_len) w_next = SYNC;
            SYNC:      w_next = (r_rem != 12'd0) ? PAYLOAD : TAIL;
            PAYLOAD:   if (r_rem == 12'd0) w_next = TAIL;
`ifdef BURST_MODE_FRAMER_EOB_EN
            EOB:       w_next = LASER_OFF;
`endif
            LASER_OFF: if (r_cnt == LOFF) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start           = r_state == IDLE && w_next == LASER_ON;
        w_hold            = w_next == r_state && (r_state == LASER_ON || r_state == PREAMBLE || r_state == LASER_OFF);
        out_payload_ready = (r_state == SYNC || r_state == PAYLOAD) && r_rem != 12'd0;
        w_accept          = out_payload_ready && in_payload_valid;
        w_data            = (w_next == PREAMBLE) ? PREAMBLE_PATTERN :
                            (w_next == SYNC)     ? r_sync :
                            (w_next == PAYLOAD)  ? (in_payload_valid ? in_payload_data : PREAMBLE_PATTERN) :
`ifdef BURST_MODE_FRAMER_EOB_EN
                            (w_next == EOB)      ? ~r_sync :
`endif
                            32'd0;
    end

    assign out_data     = r_data;
    assign out_burst_en = r_burst_en;
    assign out_busy     = r_busy;
    assign out_done     = r_done;
    assign out_underrun = r_underrun;
endmodule

// File: tb/tb_burst_mode_framer.sv
// tb_burst_mode_framer: scoreboard bench; each burst's expected line stream is built from the framing rules
// and queued, while a monitor pops one entry for every cycle the DUT is busy or pulses done.
module tb_burst_mode_framer;
    localparam int          LON = 4;
    localparam int          LOFF = 4;
    localparam logic [31:0] PAT = 32'hAAAAAAAA;

    typedef struct packed {
        logic [31:0] d;
        logic        en;
        logic        busy;
        logic        done;
        logic        ur;
    } exp_t;

    logic        in_clock;
    logic        rst;
    logic        in_start;
    logic [7:0]  in_preamble_len;
    logic [31:0] in_syncword;
    logic [11:0] in_payload_len;
    logic [31:0] in_payload_data;
    logic        in_payload_valid;
    logic        out_payload_ready;
    logic [31:0] out_data;
    logic        out_burst_en;
    logic        out_busy;
    logic        out_done;
    logic        out_underrun;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    burst_mode_framer dut (
        .in_clock(in_clock),
        .rst(rst),
        .in_start(in_start),
        .in_preamble_len(in_preamble_len),
        .in_syncword(in_syncword),
        .in_payload_len(in_payload_len),
        .in_payload_data(in_payload_data),
        .in_payload_valid(in_payload_valid),
        .out_payload_ready(out_payload_ready),
        .out_data(out_data),
        .out_burst_en(out_burst_en),
        .out_busy(out_busy),
        .out_done(out_done),
        .out_underrun(out_underrun)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    always @(negedge in_clock) begin
        if (out_busy === 1'b1 || out_done === 1'b1) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream: unexpected output data=%h en=%b busy=%b done=%b", out_data, out_burst_en, out_busy, out_done);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_burst_en, out_busy, out_done, out_underrun} !== e) begin
                    miscompares++;
                    $display("FAIL stream: got data=%h en=%b busy=%b done=%b ur=%b, want data=%h en=%b busy=%b done=%b ur=%b",
                             out_data, out_burst_en, out_busy, out_done, out_underrun, e.d, e.en, e.busy, e.done, e.ur);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    function automatic void push(input logic [31:0] d, input logic en, input logic busy, input logic done, input logic ur);
        exp_t e;
        e = '{d: d, en: en, busy: busy, done: done, ur: ur};
        exp_q.push_back(e);
    endfunction

    task automatic run_burst(input int pre, input int pay, input logic [31:0] sync, input int gmax, input int gfirst,
                             input bit seq, input bit pulse_mid, input bit pulse_done);
        logic [31:0] words[$];
        int          gaps[$];
        int          gsum = 0;
        int          idx = 0;
        int          gl = 0;
        int          rdy = 0;
        bit          done_seen = 0;
        logic        ur = 1'b0;
        for (int i = 0; i < pay; i++) begin
            words.push_back(seq ? 32'(i + 1) : $urandom());
            gaps.push_back((i == 0 && gfirst >= 0) ? gfirst : int'($urandom_range(0, gmax)));
            gsum += gaps[i];
        end
        for (int i = 0; i < LON; i++) push(32'd0, 1'b1, 1'b1, 1'b0, ur);
        for (int i = 0; i < pre; i++) push(PAT, 1'b1, 1'b1, 1'b0, ur);
        push(sync, 1'b1, 1'b1, 1'b0, ur);
        for (int i = 0; i < pay; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                ur = 1'b1;
                push(PAT, 1'b1, 1'b1, 1'b0, ur);
            end
            push(words[i], 1'b1, 1'b1, 1'b0, ur);
        end
`ifdef BURST_MODE_FRAMER_EOB_EN
        push(~sync, 1'b1, 1'b1, 1'b0, ur);
`endif
        for (int i = 0; i < LOFF; i++) push(32'd0, 1'b1, 1'b1, 1'b0, ur);
        push(32'd0, 1'b0, 1'b0, 1'b1, ur);
        if (pay > 0) gl = gaps[0];
        @(negedge in_clock);
        in_start = 1'b1;
        in_preamble_len = 8'(pre);
        in_payload_len = 12'(pay);
        in_syncword = sync;
        for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
            @(negedge in_clock);
            in_start = 1'b0;
            in_payload_valid = 1'b0;
            in_syncword = $urandom();
            if (out_done === 1'b1) begin
                done_seen = 1;
                if (pulse_done) in_start = 1'b1;
            end
            if (out_payload_ready === 1'b1) begin
                rdy++;
                if (pulse_mid && idx == pay / 2) in_start = 1'b1;
                if (gl > 0) gl--;
                else if (idx < pay) begin
                    in_payload_valid = 1'b1;
                    in_payload_data = words[idx];
                    idx++;
                    if (idx < pay) gl = gaps[idx];
                end
            end
        end
        if (!done_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no out_done within budget");
        end
        @(negedge in_clock);
        in_start = 1'b0;
        repeat (6) begin
            if (out_payload_ready === 1'b1) rdy++;
            @(negedge in_clock);
        end
        check("ready_cycles", 32'(rdy), 32'(pay + gsum));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int pre;
        int k;
        rst = 1'b0;
        in_start = 1'b0;
        in_preamble_len = 8'd0;
        in_syncword = 32'd0;
        in_payload_len = 12'd0;
        in_payload_data = 32'd0;
        in_payload_valid = 1'b0;
        repeat (3) @(negedge in_clock);
        check("reset_data", out_data, 32'd0);
        check("reset_flags", {28'd0, out_burst_en, out_busy, out_done, out_underrun}, 32'd0);
        check("reset_ready", {31'd0, out_payload_ready}, 32'd0);
        rst = 1'b1;
        @(negedge in_clock);

        run_burst(2, 3, 32'hB2C50FA1, 0, -1, 1, 0, 0);
        run_burst(0, 0, $urandom(), 0, -1, 0, 0, 0);
        run_burst(1, 2, $urandom(), 0, 3, 0, 0, 0);
        check("underrun_sticky", {31'd0, out_underrun}, 32'd1);
        run_burst(3, 5, $urandom(), 1, -1, 0, 1, 1);

        // abort mid-preamble: only the words before the reset edge are expected
        pre = int'($urandom_range(3, 8));
        k = int'($urandom_range(1, pre - 1));
        for (int i = 0; i < LON; i++) push(32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < k; i++) push(PAT, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge in_clock);
        in_start = 1'b1;
        in_preamble_len = 8'(pre);
        in_payload_len = 12'd3;
        in_syncword = $urandom();
        @(negedge in_clock);
        in_start = 1'b0;
        repeat (LON + k - 1) @(negedge in_clock);
        rst = 1'b0;
        @(negedge in_clock);
        rst = 1'b1;
        check("abort_data", out_data, 32'd0);
        check("abort_flags", {28'd0, out_burst_en, out_busy, out_done, out_underrun}, 32'd0);
        repeat (12) @(negedge in_clock);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        rst = 1'b0;
        in_start = 1'b1;
        @(negedge in_clock);
        rst = 1'b1;
        in_start = 1'b0;
        check("rst_over_start", {30'd0, out_busy, out_burst_en}, 32'd0);
        repeat (3) @(negedge in_clock);

        for (int n = 0; n < 12; n++)
            run_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 10)), $urandom(), int'($urandom_range(0, 3)), -1,
                      0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        run_burst(255, 4095, $urandom(), 0, -1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
